// File: rtl/data_fifo_if.sv
// -----------------------------------------------------------------------------
// data_fifo_if
// Bundle of the data path signals shared by the DMA, the SD physical data
// layer and the data FIFO. The clock and reset are not part of the bundle.
//
//   iClear        flush request (driven by the controller side)
//   iWriteRead    transfer direction, 1 = write to card
//   iWrite_enable push request
//   iData         push data
//   iRead_enable  pop request
//   oData         registered pop data
//   oFull/oEmpty  occupancy decodes
//   oCount        occupancy, 0..2^ADDR_WIDTH
//   oFIFO_ok      "enough data / enough room to start a transfer"
//   oOverflow     sticky rejected-push flag
//   oUnderflow    sticky rejected-pop flag
//
// master: the side that issues requests and observes status.
// slave : the FIFO itself.
// -----------------------------------------------------------------------------
interface data_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  iClear;
  logic                  iWriteRead;
  logic                  iWrite_enable;
  logic [DATA_WIDTH-1:0] iData;
  logic                  iRead_enable;
  logic [DATA_WIDTH-1:0] oData;
  logic                  oFull;
  logic                  oEmpty;
  logic [ADDR_WIDTH:0]   oCount;
  logic                  oFIFO_ok;
  logic                  oOverflow;
  logic                  oUnderflow;

  modport master (
    output iClear, iWriteRead, iWrite_enable, iData, iRead_enable,
    input  oData, oFull, oEmpty, oCount, oFIFO_ok, oOverflow, oUnderflow
  );

  modport slave (
    input  iClear, iWriteRead, iWrite_enable, iData, iRead_enable,
    output oData, oFull, oEmpty, oCount, oFIFO_ok, oOverflow, oUnderflow
  );
endinterface

// File: rtl/data_fifo.sv
// -----------------------------------------------------------------------------
// data_fifo
// Synchronous word FIFO between the DMA and the SD data path. Depth is
// 2^ADDR_WIDTH words. Pop data is registered (one cycle latency). Occupancy
// flags and the transfer qualifier oFIFO_ok are decoded from the count
// register; overflow/underflow are sticky until iClear or reset.
//
// Ports:
//   iClock  system clock, rising edge
//   iReset  asynchronous active-low reset
//   bus     data_fifo_if.slave (requests in, data/status out)
// -----------------------------------------------------------------------------
module data_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int OK_LEVEL   = 8
) (
  input  logic       iClock,
  input  logic       iReset,
  data_fifo_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   OK_C      = (ADDR_WIDTH+1)'(OK_LEVEL);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   free_space;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full;
  logic                  empty;
  logic                  pop_ok;
  logic                  push_ok;

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign free_space = DEPTH_C - count;

  // A push into a full FIFO is still accepted when a pop frees a slot in the
  // same cycle; the pop itself never depends on the push.
  assign pop_ok  = bus.iRead_enable & ~empty;
  assign push_ok = bus.iWrite_enable & (~full | pop_ok);

  assign bus.oFull      = full;
  assign bus.oEmpty     = empty;
  assign bus.oCount     = count;
  assign bus.oData      = data_q;
  assign bus.oOverflow  = overflow_q;
  assign bus.oUnderflow = underflow_q;

  // On card writes the data layer needs OK_LEVEL words queued; on card reads
  // it needs OK_LEVEL free slots to land a block.
  assign bus.oFIFO_ok = bus.iWriteRead ? (count >= OK_C) : (free_space >= OK_C);

  // Storage has no reset; a flush blocks the write so it cannot land.
  always_ff @(posedge iClock) begin
    if (push_ok && !bus.iClear) begin
      mem[wr_ptr] <= bus.iData;
    end
  end

  // Pointers, count, pop data and sticky error flags.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.iClear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        data_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
      if (bus.iWrite_enable && !push_ok) begin
        overflow_q <= 1'b1;
      end
      if (bus.iRead_enable && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_fifo.sv
// -----------------------------------------------------------------------------
// tb_data_fifo
// Self-checking bench for data_fifo. A queue-based reference model tracks the
// FIFO contents, pop data and sticky flags; a compare process checks every
// DUT output against it on each falling clock edge. Directed sequences pin
// the model with literal expectations, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_data_fifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int OKL   = 8;

  logic iClock = 1'b0;
  logic iReset = 1'b1;

  always #5 iClock = ~iClock;

  data_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .OK_LEVEL  (OKL)
  ) dut (
    .iClock(iClock),
    .iReset(iReset),
    .bus   (bus)
  );

  int   total  = 0;
  int   bad    = 0;
  bit   chk_en = 1'b0;

  logic [31:0] mq [$];
  logic [31:0] m_data = '0;
  bit          m_ovf  = 1'b0;
  bit          m_unf  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus the last popped value.
  always @(posedge iClock or negedge iReset) begin : model
    bit pop;
    bit push;
    if (!iReset) begin
      mq.delete();
      m_data = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else if (bus.iClear) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      pop  = bus.iRead_enable && (mq.size() > 0);
      push = bus.iWrite_enable && ((mq.size() < DEPTH) || pop);
      if (bus.iRead_enable && mq.size() == 0) m_unf = 1'b1;
      if (bus.iWrite_enable && !push) m_ovf = 1'b1;
      if (pop) m_data = mq.pop_front();
      if (push) mq.push_back(bus.iData);
    end
  end

  function automatic bit modelOk();
    if (bus.iWriteRead) return (mq.size() >= OKL);
    return ((DEPTH - mq.size()) >= OKL);
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge iClock) begin
    if (chk_en) begin
      checkOutput("cmp_count", 32'(bus.oCount), 32'(mq.size()));
      checkOutput("cmp_full", 32'(bus.oFull), 32'(mq.size() == DEPTH));
      checkOutput("cmp_empty", 32'(bus.oEmpty), 32'(mq.size() == 0));
      checkOutput("cmp_ok", 32'(bus.oFIFO_ok), 32'(modelOk()));
      checkOutput("cmp_ovf", 32'(bus.oOverflow), 32'(m_ovf));
      checkOutput("cmp_unf", 32'(bus.oUnderflow), 32'(m_unf));
      checkOutput("cmp_data", bus.oData, m_data);
    end
  end

  // Drive one cycle of requests, let the edge consume them, then release.
  task automatic applyStimulus(input bit we, input logic [31:0] d,
                               input bit re, input bit clr);
    bus.iWrite_enable = we;
    bus.iData         = d;
    bus.iRead_enable  = re;
    bus.iClear        = clr;
    @(posedge iClock);
    #2;
    bus.iWrite_enable = 1'b0;
    bus.iRead_enable  = 1'b0;
    bus.iClear        = 1'b0;
  endtask

  initial begin
    int peak;
    bus.iClear        = 1'b0;
    bus.iWriteRead    = 1'b1;
    bus.iWrite_enable = 1'b0;
    bus.iData         = '0;
    bus.iRead_enable  = 1'b0;

    // Reset state
    #3 iReset = 1'b0;
    #4;
    checkOutput("rst_count", 32'(bus.oCount), 32'd0);
    checkOutput("rst_empty", 32'(bus.oEmpty), 32'd1);
    checkOutput("rst_full", 32'(bus.oFull), 32'd0);
    checkOutput("rst_ok_wr", 32'(bus.oFIFO_ok), 32'd0);
    checkOutput("rst_data", bus.oData, 32'd0);
    bus.iWriteRead = 1'b0;
    #1;
    checkOutput("rst_ok_rd", 32'(bus.oFIFO_ok), 32'd1);
    bus.iWriteRead = 1'b1;
    chk_en = 1'b1;
    @(posedge iClock);
    #2 iReset = 1'b1;

    // Fill to full, then one rejected push
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(i + 1), 1'b0, 1'b0);
    checkOutput("fill_count", 32'(bus.oCount), 32'd16);
    checkOutput("fill_full", 32'(bus.oFull), 32'd1);
    checkOutput("fill_ok", 32'(bus.oFIFO_ok), 32'd1);
    checkOutput("fill_ovf", 32'(bus.oOverflow), 32'd0);
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    checkOutput("ovf_flag", 32'(bus.oOverflow), 32'd1);
    checkOutput("ovf_count", 32'(bus.oCount), 32'd16);

    // Drain, then a pop on empty
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("drain_data", bus.oData, 32'(i + 1));
    end
    checkOutput("drain_empty", 32'(bus.oEmpty), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("unf_flag", 32'(bus.oUnderflow), 32'd1);
    checkOutput("unf_data", bus.oData, 32'h10);

    // Flush clears the sticky flags
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("clr_ovf", 32'(bus.oOverflow), 32'd0);
    checkOutput("clr_unf", 32'(bus.oUnderflow), 32'd0);

    // Wrap-around: three rounds of 10 in / 10 out
    peak = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        applyStimulus(1'b1, 32'(32'h100 + r * 16 + i), 1'b0, 1'b0);
        if (int'(bus.oCount) > peak) peak = int'(bus.oCount);
      end
      for (int i = 0; i < 10; i++) begin
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("wrap_data", bus.oData, 32'(32'h100 + r * 16 + i));
      end
    end
    checkOutput("wrap_peak", 32'(peak), 32'd10);
    checkOutput("wrap_flags", 32'({bus.oOverflow, bus.oUnderflow}), 32'd0);

    // Simultaneous push+pop while full
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(32'h200 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hCAFE, 1'b1, 1'b0);
    checkOutput("fullpp_count", 32'(bus.oCount), 32'd16);
    checkOutput("fullpp_ovf", 32'(bus.oOverflow), 32'd0);
    checkOutput("fullpp_data", bus.oData, 32'h200);

    // Simultaneous push+pop while empty
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b0);
    checkOutput("emptypp_count", 32'(bus.oCount), 32'd1);
    checkOutput("emptypp_unf", 32'(bus.oUnderflow), 32'd1);
    checkOutput("emptypp_data", bus.oData, 32'h200);

    // oFIFO_ok threshold, write direction
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
      checkOutput("okwr_level", 32'(bus.oFIFO_ok), 32'(i == 7));
    end

    // oFIFO_ok threshold, read direction
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    bus.iWriteRead = 1'b0;
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
    checkOutput("okrd_nine", 32'(bus.oFIFO_ok), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("okrd_eight", 32'(bus.oFIFO_ok), 32'd1);
    bus.iWriteRead = 1'b1;

    // Flush wins over a push at count 5
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h77, 1'b0, 1'b1);
    checkOutput("clrpush_count", 32'(bus.oCount), 32'd0);
    checkOutput("clrpush_unf", 32'(bus.oUnderflow), 32'd0);
    checkOutput("clrpush_empty", 32'(bus.oEmpty), 32'd1);

    // Asynchronous reset mid-cycle at count 6
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'(32'h300 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    #1 iReset = 1'b0;
    #1;
    checkOutput("arst_count", 32'(bus.oCount), 32'd0);
    checkOutput("arst_empty", 32'(bus.oEmpty), 32'd1);
    checkOutput("arst_data", bus.oData, 32'd0);
    checkOutput("arst_ok", 32'(bus.oFIFO_ok), 32'd0);
    @(posedge iClock);
    #2 iReset = 1'b1;

    // Randomized traffic, biased in windows toward filling or draining
    for (int c = 0; c < 800; c++) begin
      bit fill_phase;
      fill_phase = ((c / 60) % 2) == 0;
      if (c % 50 == 0) bus.iWriteRead = 1'($urandom_range(0, 1));
      applyStimulus(($urandom_range(0, 99) < (fill_phase ? 80 : 30)),
                    $urandom,
                    ($urandom_range(0, 99) < (fill_phase ? 30 : 80)),
                    ($urandom_range(0, 79) == 0));
    end

    @(negedge iClock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_fifo.md
# data_fifo

Synchronous 32-bit word FIFO between the DMA and the SD data path. On SD writes the DMA fills it and the physical data layer drains it. On SD reads the physical layer fills it and the DMA drains it. It produces the `oFIFO_ok` qualifier that the data control FSM waits on before entering TRANSMIT, and it reports occupancy plus sticky overflow/underflow errors to the register block.

## Interface
- `DATA_WIDTH`, 32, word width.
- `ADDR_WIDTH`, 4, depth = 2^ADDR_WIDTH = 16 words.
- `OK_LEVEL`, 8, words required before a transfer may start (see `oFIFO_ok`). Legal range 1..2^ADDR_WIDTH.
- `iClock`  in  1  system clock; all logic on its rising edge.
- `iReset`  in  1  asynchronous, active-low reset.
- `iClear`  in  1  synchronous flush: empties the FIFO and clears the error flags.
- `iWriteRead`  in  1  transfer direction, 1 = write to card, 0 = read from card; selects the `oFIFO_ok` rule.
- `iWrite_enable`  in  1  push request.
- `iData`  in  DATA_WIDTH  push data.
- `iRead_enable`  in  1  pop request.
- `oData`  out  DATA_WIDTH  registered pop data.
- `oFull`  out  1  count == 2^ADDR_WIDTH.
- `oEmpty`  out  1  count == 0.
- `oCount`  out  ADDR_WIDTH+1  current occupancy, 0..2^ADDR_WIDTH.
- `oFIFO_ok`  out  1  when `iWriteRead`=1: count >= OK_LEVEL. When `iWriteRead`=0: free space (2^ADDR_WIDTH − count) >= OK_LEVEL.
- `oOverflow`  out  1  sticky: a push was attempted while full and not popped in the same cycle.
- `oUnderflow`  out  1  sticky: a pop was attempted while empty.

## Operation
- **Storage.** 2^ADDR_WIDTH × DATA_WIDTH register array.
- **Pointers.** Write pointer and read pointer are ADDR_WIDTH bits and wrap modulo depth with no special case. Count is ADDR_WIDTH+1 bits.
- **Push.** Accepted when `iWrite_enable`=1 and (!full or pop accepted in the same cycle). An accepted push writes `iData` at the write pointer and increments the write pointer.
- **Pop.** Accepted when `iRead_enable`=1 and !empty. An accepted pop loads `mem[rd_ptr]` into `oData` and increments the read pointer.
- **Count update.**
  - Push only: +1.
  - Pop only: −1.
  - Both, or neither: unchanged.
- **Simultaneous push+pop when empty.** The pop is rejected: `oUnderflow` is set and `oData` holds. The push is accepted, so count becomes 1.
- **Simultaneous push+pop when full.** Both are accepted and count stays at depth. `oOverflow` is not set.
- **Rejected push.** Memory is unchanged and `oOverflow` is set to 1. It stays set until `iClear` or reset.
- **Rejected pop.** `oUnderflow` is set to 1 and is sticky in the same way.
- **`iClear`.** Has priority over push and pop in the same cycle. Pointers and count go to 0, both sticky flags go to 0, and `oData` holds its value. Memory contents are not cleared.
- **Flags.** `oFull`, `oEmpty`, `oCount` and `oFIFO_ok` are combinational decodes of the registered count, plus `iWriteRead` for `oFIFO_ok`. They carry no extra state.
- There is no FSM beyond the pointer and count registers.

## Timing
- **Reset.** Asserting `iReset` low immediately (asynchronously) forces:
  - pointers = 0, count = 0;
  - `oData` = 0, `oOverflow` = 0, `oUnderflow` = 0;
  - therefore `oEmpty` = 1, `oFull` = 0, `oCount` = 0;
  - `oFIFO_ok` = 0 when `iWriteRead`=1, and 1 when `iWriteRead`=0.

  Reset during an active transfer discards all contents. Memory array contents are unspecified after reset.
- **Push latency.** A word pushed at edge N is poppable from edge N+1. Count and flags reflect the push after edge N.
- **Pop latency.** 1 cycle. With `iRead_enable` high before edge N, `oData` is valid after edge N and held until the next accepted pop.
- **Sustained throughput.** Back-to-back push and/or pop at 1 word per cycle, with no bubbles.
- **`oFIFO_ok`.** Changes in the same cycle as the count or `iWriteRead` change. Consumers sample it on `iClock`.

## Test plan
- **Reset and fill to full.** Reset, then push 0x00000001..0x00000010 on 16 consecutive cycles. Required: `oCount` = 16, `oFull` = 1, `oFIFO_ok` = 1 (`iWriteRead`=1), `oOverflow` = 0. Then push 0xDEADBEEF: `oOverflow` = 1, and the count and contents are unchanged.
- **Drain and underflow.** Pop 16 times. Required: `oData` sequence is 0x1..0x10, each value one cycle after its pop request. Afterwards `oEmpty` = 1. A 17th pop sets `oUnderflow` = 1 and `oData` stays 0x10.
- **Wrap-around.** Repeat push 10 / pop 10 three times (pointers cross 15→0). Required: data order is preserved, `oCount` peaks at 10, and no error flags are set.
- **Simultaneous at boundaries.**
  - Full + push&pop: count stays 16, no overflow, and the oldest word is output.
  - Empty + push&pop: count becomes 1 and `oUnderflow` = 1.
- **`oFIFO_ok` threshold.**
  - `iWriteRead`=1: ok rises exactly when count goes 7→8.
  - `iWriteRead`=0 with 9 words: ok = 0; after one pop (8 words, 8 free), ok = 1.
- **`iClear` and async reset.**
  - `iClear` asserted together with a push at count 5: count becomes 0 and flags clear.
  - Drop `iReset` mid-cycle while count is 6: outputs go to their reset values before the next clock edge.
